// File: rtl/fadd_norm_pipe_if.sv
// Handshake/data bundle between the FP adder align/add stage and the
// normalise-round-pack pipe. EW/FW must match the attached fadd_norm_pipe.
// master: producer + result consumer side; slave: the pipe itself.
interface fadd_norm_pipe_if #(
    parameter int EW = 8,
    parameter int FW = 23
) ();
    localparam int CW = FW + 5;

    logic              in_valid;
    logic              in_ready;
    logic [CW-1:0]     cal_frac;
    logic [EW-1:0]     temp_exp;
    logic [FW-1:0]     inf_nan_frac;
    logic [1:0]        rm;
    logic              is_nan;
    logic              is_inf;
    logic              sign;
    logic              out_valid;
    logic              out_ready;
    logic [EW+FW:0]    s;
    logic              flag_ovf;
    logic              flag_unf;
    logic              flag_inx;

    modport master (
        output in_valid, cal_frac, temp_exp, inf_nan_frac, rm, is_nan, is_inf, sign, out_ready,
        input  in_ready, out_valid, s, flag_ovf, flag_unf, flag_inx
    );

    modport slave (
        input  in_valid, cal_frac, temp_exp, inf_nan_frac, rm, is_nan, is_inf, sign, out_ready,
        output in_ready, out_valid, s, flag_ovf, flag_unf, flag_inx
    );
endinterface

// File: rtl/fadd_norm_pipe.sv
// Normalise / round / pack stage of the FP adder, three register stages.
// Latency 3 register edges (accept edge included), 1 beat/cycle throughput.
// Backpressure: per-stage ready = ~valid | downstream ready, bubbles collapse.
// Ports: clk, rst (async, active-high), io_bus (fadd_norm_pipe_if.slave):
//   in_valid/in_ready, cal_frac, temp_exp, inf_nan_frac, rm, is_nan, is_inf,
//   sign -> out_valid/out_ready, s {sign,exp,frac}, flag_ovf/unf/inx.
module fadd_norm_pipe #(
    parameter int EW = 8,
    parameter int FW = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    fadd_norm_pipe_if.slave      io_bus
);
    localparam int CW  = FW + 5;
    localparam int NW  = CW - 1;          // bits searched for the leading one
    localparam int LZW = $clog2(NW);

    // ---------------- handshake ----------------
    logic r_v1, r_v2, r_v3;
    logic w_rdy1, w_rdy2, w_rdy3;

    assign w_rdy3           = ~r_v3 | io_bus.out_ready;
    assign w_rdy2           = ~r_v2 | w_rdy3;
    assign w_rdy1           = ~r_v1 | w_rdy2;
    assign io_bus.in_ready  = w_rdy1;
    assign io_bus.out_valid = r_v3;

    // ---------------- S1: normalise ----------------
    // Log2 leading-zero shifter: stage i tests the top 2^(LZW-1-i) bits and
    // shifts them out when all zero. Greedy power-of-two steps give the exact
    // count for any nonzero input; an all-zero input is handled by w_nz.
    logic [LZW:0][NW-1:0] w_stg;
    logic [LZW-1:0]       w_z;
    logic                 w_nz;

    assign w_stg[0] = io_bus.cal_frac[CW-2:0];
    assign w_nz     = |io_bus.cal_frac[CW-2:0];

    for (genvar i = 0; i < LZW; i++) begin : g_lzc
        localparam int SH = 1 << (LZW - 1 - i);
        assign w_z[LZW-1-i] = (w_stg[i][NW-1 -: SH] == '0);
        assign w_stg[i+1]   = w_z[LZW-1-i] ? (w_stg[i] << SH) : w_stg[i];
    end

    // frac0 drops the carry position: after normalisation it is always zero.
    logic [CW-2:0] w_frac0;
    logic [EW-1:0] w_exp0;

    always_comb begin
        w_frac0 = io_bus.cal_frac[CW-2:0];
        w_exp0  = '0;
        if (io_bus.cal_frac[CW-1]) begin
            // carry: shift right one, keep the dropped bit alive in sticky
            w_frac0 = {io_bus.cal_frac[CW-1:2], |io_bus.cal_frac[1:0]};
            w_exp0  = io_bus.temp_exp + 1'b1;
        end else if (w_nz && (io_bus.temp_exp > EW'(w_z))) begin
            w_frac0 = w_stg[LZW];
            w_exp0  = io_bus.temp_exp - EW'(w_z);
        end else if (io_bus.temp_exp != '0) begin
            // not enough exponent range: shift only down to the denormal point
            w_frac0 = io_bus.cal_frac[CW-2:0] << (io_bus.temp_exp - 1'b1);
        end
    end

    logic [CW-2:0] r1_frac0;
    logic [EW-1:0] r1_exp0;
    logic [1:0]    r1_rm;
    logic          r1_sign, r1_nan, r1_inf;
    logic [FW-1:0] r1_pay;

    // ---------------- S2: round ----------------
    logic          w_inc, w_grs, w_ovf;
    logic [FW+1:0] w_fr;
    logic [EW-1:0] w_exp;

    assign w_grs = |r1_frac0[2:0];

    always_comb begin
        case (r1_rm)
            2'b00:   w_inc = r1_frac0[2] & (r1_frac0[1] | r1_frac0[0] | r1_frac0[3]);
            2'b01:   w_inc = w_grs & r1_sign;
            2'b10:   w_inc = w_grs & ~r1_sign;
            default: w_inc = 1'b0;
        endcase
    end

    assign w_fr = {1'b0, r1_frac0[CW-2:3]} + (FW+2)'(w_inc);

    always_comb begin
        w_exp = r1_exp0;
        if (w_fr[FW+1])
            w_exp = r1_exp0 + 1'b1;
        else if ((r1_exp0 == '0) && w_fr[FW])
            w_exp = {{(EW-1){1'b0}}, 1'b1};   // denormal rounded into normal range
    end

    assign w_ovf = (&r1_exp0) | (&w_exp);

    logic [EW-1:0] r2_exp;
    logic [FW-1:0] r2_frac;
    logic          r2_ovf, r2_grs, r2_sign, r2_nan, r2_inf;
    logic [1:0]    r2_rm;
    logic [FW-1:0] r2_pay;

    // ---------------- S3: pack ----------------
    logic [EW+FW:0] w_s;
    logic           w_fovf, w_funf, w_finx, w_to_inf;

    assign w_to_inf = (r2_rm == 2'b00) | ((r2_rm == 2'b01) & r2_sign) |
                      ((r2_rm == 2'b10) & ~r2_sign);

    always_comb begin
        w_s    = {r2_sign, r2_exp, r2_frac};
        w_fovf = r2_ovf;
        w_finx = r2_grs | r2_ovf;
        if (r2_nan) begin
            w_s    = {1'b1, {EW{1'b1}}, r2_pay};
            w_fovf = 1'b0;
            w_finx = 1'b0;
        end else if (r2_inf) begin
            w_s    = {r2_sign, {EW{1'b1}}, r2_pay};
            w_fovf = 1'b0;
            w_finx = 1'b0;
        end else if (r2_ovf) begin
            w_s = w_to_inf ? {r2_sign, {EW{1'b1}}, {FW{1'b0}}}
                           : {r2_sign, {{(EW-1){1'b1}}, 1'b0}, {FW{1'b1}}};
        end
        w_funf = w_finx & (w_s[EW+FW-1:FW] == '0);
    end

    // ---------------- registers ----------------
    logic [EW+FW:0] r_s;
    logic           r_fovf, r_funf, r_finx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_s    <= '0;
            r_fovf <= 1'b0;
            r_funf <= 1'b0;
            r_finx <= 1'b0;
        end else begin
            if (w_rdy1) r_v1 <= io_bus.in_valid;
            if (w_rdy2) r_v2 <= r_v1;
            if (w_rdy3) begin
                r_v3 <= r_v2;
                // outputs only change when a new beat lands, so they hold in stalls
                if (r_v2) begin
                    r_s    <= w_s;
                    r_fovf <= w_fovf;
                    r_funf <= w_funf;
                    r_finx <= w_finx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_rdy1 && io_bus.in_valid) begin
            r1_frac0 <= w_frac0;
            r1_exp0  <= w_exp0;
            r1_rm    <= io_bus.rm;
            r1_sign  <= io_bus.sign;
            r1_nan   <= io_bus.is_nan;
            r1_inf   <= io_bus.is_inf;
            r1_pay   <= io_bus.inf_nan_frac;
        end
        if (w_rdy2 && r_v1) begin
            r2_exp  <= w_exp;
            r2_frac <= w_fr[FW-1:0];
            r2_ovf  <= w_ovf;
            r2_grs  <= w_grs;
            r2_rm   <= r1_rm;
            r2_sign <= r1_sign;
            r2_nan  <= r1_nan;
            r2_inf  <= r1_inf;
            r2_pay  <= r1_pay;
        end
    end

    assign io_bus.s        = r_s;
    assign io_bus.flag_ovf = r_fovf;
    assign io_bus.flag_unf = r_funf;
    assign io_bus.flag_inx = r_finx;
endmodule

// File: tb/tb_fadd_norm_pipe.sv
// Scoreboard bench for fadd_norm_pipe (single precision): directed vectors,
// backpressure, async reset mid-stream and randomized beats vs a reference model.
module tb_fadd_norm_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fadd_norm_pipe_if #(.EW(8), .FW(23)) bus ();
    fadd_norm_pipe #(.EW(8), .FW(23)) dut (.clk(clk), .rst(rst), .io_bus(bus));

    typedef struct {
        logic [34:0] exp;   // {s, ovf, unf, inx}
        bit          lat;
        int          acc;
    } sb_t;

    sb_t q[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  mode = 0;          // 0: out_ready=1, 1: random, 2: out_ready=0

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Reference: value-level normalise, then round-to-integer on the kept bits.
    function automatic logic [34:0] ref_model(input logic [27:0] cal, input logic [7:0] te,
                                              input logic [1:0] rmv, input logic sg,
                                              input logic nan, input logic inf,
                                              input logic [22:0] pay);
        logic [27:0] f;
        int e, ee, z, keep, rem, r;
        bit inc, ov, ix, uf, to_inf;
        logic [31:0] res;
        if (cal[27]) begin
            f = (cal >> 1) | (cal & 28'd1);
            e = int'(te) + 1;
        end else begin
            z = 0;
            while (z < 27 && cal[26-z] == 1'b0) z++;
            if (z < 27 && int'(te) > z) begin
                f = cal << z;
                e = int'(te) - z;
            end else begin
                e = 0;
                f = (te != 8'd0) ? (cal << (int'(te) - 1)) : cal;
            end
        end
        keep = int'(f >> 3);
        rem  = int'(f & 28'd7);
        case (rmv)
            2'b00:   inc = (rem > 4) || (rem == 4 && (keep % 2) == 1);
            2'b01:   inc = (rem != 0) && sg;
            2'b10:   inc = (rem != 0) && !sg;
            default: inc = 1'b0;
        endcase
        r  = keep + int'(inc);
        ee = e;
        if (r >= (1 << 24)) ee = e + 1;
        else if (e == 0 && r >= (1 << 23)) ee = 1;
        ov = (e == 255) || (ee == 255);
        ix = (rem != 0) || ov;
        to_inf = (rmv == 2'b00) || (rmv == 2'b01 && sg) || (rmv == 2'b10 && !sg);
        if (nan) begin
            res = {1'b1, 8'hFF, pay}; ov = 1'b0; ix = 1'b0;
        end else if (inf) begin
            res = {sg, 8'hFF, pay}; ov = 1'b0; ix = 1'b0;
        end else if (ov) begin
            res = to_inf ? {sg, 8'hFF, 23'd0} : {sg, 8'hFE, 23'h7FFFFF};
        end else begin
            res = {sg, 8'(ee), 23'(r)};
        end
        uf = ix && (res[30:23] == 8'd0);
        return {res, ov, uf, ix};
    endfunction

    // out_ready driver
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: the presented output must always equal the head of the queue.
    initial begin
        logic [34:0] got;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid) begin
                got = {bus.s, bus.flag_ovf, bus.flag_unf, bus.flag_inx};
                if (q.size() == 0) begin
                    check("unexpected_output", 64'(got), 64'h0);
                    n_fail += (got == 35'd0) ? 1 : 0;  // a spurious beat is always wrong
                end else begin
                    check("result", 64'(got), 64'(q[0].exp));
                    if (bus.out_ready) begin
                        if (q[0].lat) check("latency", 64'(cyc - q[0].acc + 1), 64'd3);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic drive(input logic [27:0] cal, input logic [7:0] te, input logic [1:0] rmv,
                         input logic sg, input logic nan, input logic inf, input logic [22:0] pay,
                         input bit use_exp, input logic [34:0] e_i, input bit lat);
        bit   accepted = 1'b0;
        sb_t  ent;
        bus.cal_frac = cal; bus.temp_exp = te; bus.rm = rmv; bus.sign = sg;
        bus.is_nan = nan; bus.is_inf = inf; bus.inf_nan_frac = pay;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 300 && !accepted; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ent.exp = use_exp ? e_i : ref_model(cal, te, rmv, sg, nan, inf, pay);
                ent.lat = lat;
                ent.acc = cyc + 1;
                q.push_back(ent);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!accepted) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 1000 && q.size() > 0; t++) @(posedge clk);
        if (q.size() > 0) check("drain_timeout", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input logic [27:0] cal, input logic [7:0] te, input logic [1:0] rmv,
                            input logic sg, input logic nan, input logic inf, input logic [22:0] pay,
                            input logic [34:0] e_i);
        drain();
        drive(cal, te, rmv, sg, nan, inf, pay, 1'b1, e_i, 1'b1);
    endtask

    task automatic rand_beat();
        logic [27:0] cal;
        logic [7:0]  te;
        int          k;
        cal = 28'($urandom);
        k   = $urandom_range(0, 9);
        if (k < 3) begin
            cal = cal >> $urandom_range(0, 27);
            te  = 8'($urandom_range(0, 30));
        end else begin
            te  = 8'($urandom_range(1, 254));
        end
        k = $urandom_range(0, 19);
        drive(cal, te, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), k == 0, k == 1,
              23'($urandom), 1'b0, 35'd0, 1'b0);
    endtask

    initial begin
        #500000;
        check("watchdog", 64'd0, 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.cal_frac = '0; bus.temp_exp = '0; bus.rm = 2'b00;
        bus.sign = 1'b0; bus.is_nan = 1'b0; bus.is_inf = 1'b0; bus.inf_nan_frac = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_s", 64'(bus.s), 64'd0);
        check("rst_flags", 64'({bus.flag_ovf, bus.flag_unf, bus.flag_inx}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // directed vectors, each into an empty pipe with latency checked
        directed(28'h8000000, 8'd127, 2'b00, 1'b0, 1'b0, 1'b0, 23'd0, {32'h40000000, 3'b000});
        directed(28'h4000004, 8'd127, 2'b00, 1'b0, 1'b0, 1'b0, 23'd0, {32'h3F800000, 3'b001});
        directed(28'h400000C, 8'd127, 2'b00, 1'b0, 1'b0, 1'b0, 23'd0, {32'h3F800002, 3'b001});
        directed(28'h400000C, 8'd127, 2'b11, 1'b0, 1'b0, 1'b0, 23'd0, {32'h3F800001, 3'b001});
        directed(28'h8000000, 8'd254, 2'b00, 1'b0, 1'b0, 1'b0, 23'd0, {32'h7F800000, 3'b101});
        directed(28'h8000000, 8'd254, 2'b11, 1'b0, 1'b0, 1'b0, 23'd0, {32'h7F7FFFFF, 3'b101});
        directed(28'h8000000, 8'd254, 2'b10, 1'b1, 1'b0, 1'b0, 23'd0, {32'hFF7FFFFF, 3'b101});
        directed(28'h2000000, 8'd1,   2'b00, 1'b0, 1'b0, 1'b0, 23'd0, {32'h00400000, 3'b000});
        directed(28'h3FFFFFF, 8'd1,   2'b10, 1'b0, 1'b0, 1'b0, 23'd0, {32'h00800000, 3'b001});
        directed(28'h8000000, 8'd254, 2'b00, 1'b0, 1'b1, 1'b0, 23'h012345, {32'hFF812345, 3'b000});
        directed(28'h0000000, 8'd0,   2'b00, 1'b1, 1'b0, 1'b1, 23'd0, {32'hFF800000, 3'b000});
        drain();

        // backpressure: three beats fill the pipe, the fourth waits
        mode = 2;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rand_beat();
        @(negedge clk);
        check("in_ready_full", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        fork
            rand_beat();
            begin
                repeat (6) @(posedge clk);
                #1;
                mode = 0;
            end
        join
        drain();

        // async reset with three beats in flight
        mode = 2;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rand_beat();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_s", 64'(bus.s), 64'd0);
        q.delete();
        mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("arst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        directed(28'h8000000, 8'd127, 2'b00, 1'b0, 1'b0, 1'b0, 23'd0, {32'h40000000, 3'b000});
        drain();

        // randomized, with random backpressure and then free-flowing
        mode = 1;
        for (int i = 0; i < 400; i++) rand_beat();
        mode = 0;
        drain();
        for (int i = 0; i < 200; i++) rand_beat();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fadd_norm_pipe.md
# fadd_norm_pipe

Parametrised, pipelined normalise-round-pack stage for the FP adder. It takes the un-normalised sum, the working exponent and the special-case flags from the align/add stage, and returns a packed IEEE-754 result plus exception flags. It generalises the combinational normaliser in three ways: exponent and fraction widths are parameters (single or double precision), there are three register stages with a valid/ready handshake, and it adds sticky-preserving carry normalisation, denormal-to-normal promotion and overflow/underflow/inexact flags.

## Interface
- EW, 8, exponent width
- FW, 23, stored fraction width; working fraction CW = FW+5 (carry, hidden, FW fraction, guard, round, sticky)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  stage 1 can accept
- cal_frac  in  CW  un-normalised magnitude; bit CW-1 carry, CW-2 hidden, [2:0] G/R/S
- temp_exp  in  EW  biased exponent matching hidden-bit position
- inf_nan_frac  in  FW  payload for NaN/Inf results
- rm  in  2  00 nearest-even, 01 toward −inf, 10 toward +inf, 11 toward zero
- is_nan, is_inf, sign  in  1 each  special-case flags, result sign
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- s  out  1+EW+FW  packed result {sign, exp, frac}
- flag_ovf, flag_unf, flag_inx  out  1 each  overflow, underflow, inexact (qualified by out_valid)

## Operation
- S1, normalise:
  - If the carry bit is set: frac0 = cal_frac[CW-1:1], with the dropped bit 0 ORed into the new sticky bit 0; exp0 = temp_exp+1.
  - Else let z = leading-zero count of cal_frac[CW-2:0], computed with a log2 shifter generated from CW.
  - If temp_exp > z and the shifted MSB is 1: frac0 = cal_frac << z, exp0 = temp_exp − z.
  - Else (denormal or zero): exp0 = 0; frac0 = cal_frac << (temp_exp−1) if temp_exp≠0, else cal_frac unchanged.
- S2, round:
  - inc = RNE: G&(R|S|L); 01: (G|R|S)&sign; 10: (G|R|S)&~sign; 11: 0. L is the fraction LSB.
  - fr = {0, frac0[CW-2:3]} + inc, width FW+2.
  - exponent = exp0+1 if fr[FW+1]. Also exponent = 1 if exp0 = 0 and fr[FW] = 1 (denormal rounds up into the normal range).
  - ovf = &exp0 | &exponent.
- S3, pack:
  - Result priority: is_nan → {1, all-ones, inf_nan_frac}; else is_inf → {sign, all-ones, inf_nan_frac}; else ovf → Inf or max-finite.
  - Overflow result by rm: 00 → Inf; 01 → Inf if sign, else max; 10 → Inf if ~sign, else max; 11 → max.
  - Max-finite = {sign, all-ones−1, all-ones FW}.
  - Otherwise {sign, exponent, fr[FW-1:0]}.
- Flags:
  - All flags are 0 when is_nan or is_inf.
  - flag_inx = G|R|S at S2, or ovf.
  - flag_ovf = ovf.
  - flag_unf = inexact and the packed exponent is 0.
- rm and sign travel with their beat; no state is shared between beats.

## Timing
- Three register stages. Latency is 3 cycles from input accept to out_valid with out_ready held high. Throughput is 1 beat/cycle.
- Per-stage valid v1..v3; v3 = out_valid. Stage k loads when ready_k = ~v_k | ready_{k+1}. ready_4 = out_ready; in_ready = ready_1.
- Bubbles collapse: a stalled pipeline with empty stages keeps accepting until all three stages hold data.
- While out_valid=1 and out_ready=0, s and the flags hold stable. No beat is dropped, duplicated or reordered.
- Accept rule: input is taken on in_valid & in_ready. Output is consumed on out_valid & out_ready. Both can happen in the same cycle.
- Reset (asynchronous, any cycle including mid-stream): v1..v3 = 0, s = 0, flags = 0, in_ready = 1 once rst deasserts. In-flight beats are discarded.
- Data registers need no reset. Only valids and outputs are reset.

## Test plan
- 1.0+1.0, EW=8/FW=23: cal_frac=28'h8000000, temp_exp=127, rm=00 → s=32'h40000000, all flags 0, out_valid exactly 3 cycles after accept.
- RNE tie: cal_frac=28'h4000004 → 32'h3F800000. cal_frac=28'h400000C → 32'h3F800002. Both inx=1. Same 28'h400000C with rm=11 → 32'h3F800001.
- Overflow: cal_frac=28'h8000000, temp_exp=254, sign=0.
  - rm=00 → 32'h7F800000, ovf=inx=1.
  - rm=11 → 32'h7F7FFFFF.
  - sign=1, rm=10 → 32'hFF7FFFFF.
- Denormal: temp_exp=1, cal_frac=28'h2000000 → 32'h00400000, flags 0. cal_frac=28'h3FFFFFF, rm=10 → 32'h00800000 (promoted to normal), inx=1, unf=0.
- Backpressure: out_ready=0, stream 4 beats → in_ready drops after the 3rd accept. Raise out_ready → all 4 beats emerge in order, and s stays constant during the stall. NaN input → 32'hFF8xxxxx with the inf_nan_frac payload, flags 0.
- Reset with 3 beats in flight → out_valid=0 and s=0 immediately (asynchronous). The next beat after deassertion completes normally in 3 cycles.
